pkt_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that merges NUM_SRC Avalon-ST packet sources into one Avalon-ST sink.
- Sources are pcap readers or parser front-ends; the sink is the parser or NoC injection port.
- A grant is held from SOP to EOP, so packets never interleave.
- The output is fully registered: one register stage with ready-latency 0.

---
 rtl/pkt_rr_arbiter_if.sv | 36 +++
 rtl/pkt_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_pkt_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_rr_arbiter_if.sv
// Avalon-ST bundle for the packet round-robin arbiter: NUM_SRC packed source
// streams in, one registered sink stream out.
interface pkt_rr_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]         in_valid;
    logic [NUM_SRC-1:0]         in_ready;
    logic [NUM_SRC-1:0]         in_sop;
    logic [NUM_SRC-1:0]         in_eop;
    logic [NUM_SRC-1:0]         in_error;
    logic [NUM_SRC*EMPTY_W-1:0] in_empty;
    logic [NUM_SRC*DATA_W-1:0]  in_data;

    logic                       out_valid;
    logic                       out_ready;
    logic                       out_sop;
    logic                       out_eop;
    logic                       out_error;
    logic [EMPTY_W-1:0]         out_empty;
    logic [DATA_W-1:0]          out_data;
    logic [SRC_W-1:0]           out_src;

    modport slave (
        input  in_valid, in_sop, in_eop, in_error, in_empty, in_data, out_ready,
        output in_ready, out_valid, out_sop, out_eop, out_error, out_empty, out_data, out_src
    );

    modport master (
        output in_valid, in_sop, in_eop, in_error, in_empty, in_data, out_ready,
        input  in_ready, out_valid, out_sop, out_eop, out_error, out_empty, out_data, out_src
    );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: grant held SOP..EOP, one idle arbitration
// cycle per packet, fully registered output with ready-latency 0.
module pkt_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic             system_clk,
    input  logic             system_reset,
    pkt_rr_arbiter_if.slave  bus,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   gnt_q, gnt_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               first_q, first_d;
    logic               out_adv;
    logic               accept;
    logic [NUM_SRC-1:0] ready_c;
    logic [NUM_SRC-1:0] orphan;
    logic [CNT_W-1:0]   drop_inc;
    logic               win_found;
    logic [SRC_W-1:0]   win_idx;
    logic [SRC_W-1:0]   cand;

    logic [DATA_W-1:0]  data_arr  [NUM_SRC];
    logic [EMPTY_W-1:0] empty_arr [NUM_SRC];

    logic               vld_p1, sop_p1, eop_p1, err_p1;
    logic [EMPTY_W-1:0] empty_p1;
    logic [DATA_W-1:0]  data_p1;
    logic [SRC_W-1:0]   src_p1;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign data_arr[g]  = bus.in_data[g*DATA_W +: DATA_W];
        assign empty_arr[g] = bus.in_empty[g*EMPTY_W +: EMPTY_W];
    end

    assign out_adv = !vld_p1 || bus.out_ready;
    assign orphan  = bus.in_valid & ~bus.in_sop;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        first_d   = first_q;
        ready_c   = '0;
        accept    = 1'b0;
        drop_inc  = '0;
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        case (state_q)
            IDLE: begin
                // Scan from the farthest offset down so the nearest candidate to rr_ptr wins.
                for (int k = NUM_SRC - 1; k >= 0; k--) begin
                    cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
                    if (bus.in_valid[cand] && bus.in_sop[cand]) begin
                        win_found = 1'b1;
                        win_idx   = cand;
                    end
                end
                ready_c  = orphan;
                drop_inc = CNT_W'($countones(orphan));
                if (win_found) begin
                    gnt_d   = win_idx;
                    first_d = 1'b1;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                ready_c[gnt_q] = out_adv;
                accept         = bus.in_valid[gnt_q] && out_adv;
                if (accept) begin
                    first_d = 1'b0;
                    if (bus.in_eop[gnt_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = (gnt_q == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready = system_reset ? ready_c : '0;

    always_ff @(posedge system_clk or negedge system_reset) begin
        if (!system_reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            first_q  <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            first_q  <= first_d;
            drop_cnt <= drop_cnt + drop_inc;
            if (vld_p1 && bus.out_ready && eop_p1)
                pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
    end

    // Stage p1: registered output beat; a SOP after the first beat is flagged as an error.
    always_ff @(posedge system_clk or negedge system_reset) begin
        if (!system_reset) begin
            vld_p1   <= 1'b0;
            sop_p1   <= 1'b0;
            eop_p1   <= 1'b0;
            err_p1   <= 1'b0;
            empty_p1 <= '0;
            data_p1  <= '0;
            src_p1   <= '0;
        end else if (out_adv) begin
            vld_p1 <= accept;
            if (accept) begin
                sop_p1   <= bus.in_sop[gnt_q];
                eop_p1   <= bus.in_eop[gnt_q];
                err_p1   <= bus.in_error[gnt_q] | (bus.in_sop[gnt_q] & ~first_q);
                empty_p1 <= empty_arr[gnt_q];
                data_p1  <= data_arr[gnt_q];
                src_p1   <= gnt_q;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_sop   = sop_p1;
    assign bus.out_eop   = eop_p1;
    assign bus.out_error = err_p1;
    assign bus.out_empty = empty_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_src   = src_p1;
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: per-source beat queues feed the DUT and
// every beat the sink accepts is logged and compared against hand-built values.
module tb_pkt_rr_arbiter;
    localparam int NS = 4;
    localparam int DW = 64;
    localparam int EW = 3;
    localparam int CW = 32;

    logic          system_clk   = 1'b0;
    logic          system_reset = 1'b0;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;

    pkt_rr_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .EMPTY_W(EW)) bus ();

    pkt_rr_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)) dut (
        .system_clk   (system_clk),
        .system_reset (system_reset),
        .bus          (bus),
        .pkt_cnt      (pkt_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        logic          sop, eop, err;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic [1:0]    src;
        logic          sop, eop, err;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
        int            cyc;
    } obeat_t;

    beat_t         srcq [NS][$];
    obeat_t        olog [$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    logic          bp_mode = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_beat(input int s, input logic sop, input logic eop, input logic err,
                             input logic [EW-1:0] empty, input logic [DW-1:0] data);
        beat_t b;
        b.sop = sop; b.eop = eop; b.err = err; b.empty = empty; b.data = data;
        srcq[s].push_back(b);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) begin
                bus.in_valid[i]          = 1'b1;
                bus.in_sop[i]            = srcq[i][0].sop;
                bus.in_eop[i]            = srcq[i][0].eop;
                bus.in_error[i]          = srcq[i][0].err;
                bus.in_empty[i*EW +: EW] = srcq[i][0].empty;
                bus.in_data[i*DW +: DW]  = srcq[i][0].data;
            end else begin
                bus.in_valid[i]          = 1'b0;
                bus.in_sop[i]            = 1'b0;
                bus.in_eop[i]            = 1'b0;
                bus.in_error[i]          = 1'b0;
                bus.in_empty[i*EW +: EW] = '0;
                bus.in_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) srcq[i].delete();
        olog.delete();
        drive_inputs();
    endtask

    // Entered at a negedge; samples just before the next posedge and returns at the following negedge.
    task automatic step();
        logic [NS-1:0] fire;
        obeat_t        o;
        cyc++;
        bus.out_ready = bp_mode ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
        #1;
        fire = bus.in_valid & bus.in_ready;
        if (stall_prev) begin
            check_val("stall_hold_vld", 64'(bus.out_valid), 64'd1);
            check_val("stall_hold_data", bus.out_data, stall_data);
        end
        if (bus.out_valid && bus.out_ready) begin
            o.src = bus.out_src; o.sop = bus.out_sop; o.eop = bus.out_eop; o.err = bus.out_error;
            o.empty = bus.out_empty; o.data = bus.out_data; o.cyc = cyc;
            olog.push_back(o);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
        @(posedge system_clk);
        @(negedge system_clk);
        for (int i = 0; i < NS; i++)
            if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        drive_inputs();
    endtask

    task automatic hold_reset(input int n);
        system_reset = 1'b0;
        stall_prev   = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge system_clk);
            @(negedge system_clk);
        end
        system_reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        clear_all();
        @(negedge system_clk);

        // Reset with every source presenting a single-beat packet.
        for (int i = 0; i < NS; i++) push_beat(i, 1'b1, 1'b1, 1'b0, 3'd0, 64'hB0 + 64'(i));
        drive_inputs();
        system_reset = 1'b0;
        #1;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
        hold_reset(3);
        check_val("rst_pkt_cnt", pkt_cnt, 64'd0);
        check_val("rst_drop_cnt", drop_cnt, 64'd0);
        step();
        #1;
        check_val("first_gnt_ready", 64'(bus.in_ready), 64'b0001);
        step();
        #1;
        check_val("first_out_valid", 64'(bus.out_valid), 64'd1);
        check_val("first_out_src", 64'(bus.out_src), 64'd0);
        check_val("first_out_data", bus.out_data, 64'hB0);
        check_val("first_out_eop", 64'(bus.out_eop), 64'd1);
        repeat (20) step();
        check_val("single_beat_pkt_cnt", pkt_cnt, 64'd4);

        // Fairness: 4 sources x 3 packets x 3 beats, sink always ready.
        clear_all();
        hold_reset(2);
        bp_mode = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < NS; s++)
                for (int j = 0; j < 3; j++)
                    push_beat(s, j == 0, j == 2, 1'b0, 3'd0, 64'((s << 16) | (k << 8) | j));
        drive_inputs();
        repeat (55) step();
        check_val("fair_beats", 64'(olog.size()), 64'd36);
        if (olog.size() == 36) begin
            for (int p = 0; p < 12; p++)
                for (int j = 0; j < 3; j++) begin
                    check_val("fair_src", 64'(olog[p*3+j].src), 64'(p % 4));
                    check_val("fair_data", olog[p*3+j].data, 64'(((p % 4) << 16) | ((p / 4) << 8) | j));
                end
            check_val("fair_last_eop_cycle", 64'(olog[35].cyc), 64'd49);
        end
        check_val("fair_pkt_cnt", pkt_cnt, 64'd12);

        // Backpressure: source 2, five beats, out_ready pattern 1,0,0,1.
        clear_all();
        hold_reset(2);
        bp_mode = 1'b1;
        for (int j = 0; j < 5; j++) push_beat(2, j == 0, j == 4, 1'b0, 3'(j), 64'hA0 + 64'(j));
        drive_inputs();
        repeat (40) step();
        bp_mode = 1'b0;
        check_val("bp_beats", 64'(olog.size()), 64'd5);
        if (olog.size() == 5) begin
            for (int j = 0; j < 5; j++) begin
                check_val("bp_data", olog[j].data, 64'hA0 + 64'(j));
                check_val("bp_eop", 64'(olog[j].eop), 64'(j == 4));
                check_val("bp_empty", 64'(olog[j].empty), 64'(j));
                check_val("bp_src", 64'(olog[j].src), 64'd2);
            end
        end
        check_val("bp_pkt_cnt", pkt_cnt, 64'd1);

        // Orphans: two non-SOP beats from source 1 in IDLE, then a normal packet.
        clear_all();
        hold_reset(2);
        push_beat(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'hDEAD0);
        push_beat(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'hDEAD1);
        push_beat(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'hC0);
        push_beat(1, 1'b0, 1'b1, 1'b0, 3'd0, 64'hC1);
        drive_inputs();
        repeat (15) step();
        check_val("orph_drop_cnt", drop_cnt, 64'd2);
        check_val("orph_beats", 64'(olog.size()), 64'd2);
        if (olog.size() == 2) begin
            check_val("orph_data0", olog[0].data, 64'hC0);
            check_val("orph_data1", olog[1].data, 64'hC1);
            check_val("orph_src", 64'(olog[0].src), 64'd1);
        end

        // Nested SOP from source 3 while source 0 also requests; rr_ptr is 2 here.
        clear_all();
        push_beat(3, 1'b1, 1'b0, 1'b0, 3'd0, 64'hE0);
        push_beat(3, 1'b0, 1'b0, 1'b0, 3'd0, 64'hE1);
        push_beat(3, 1'b1, 1'b0, 1'b0, 3'd0, 64'hE2);
        push_beat(3, 1'b0, 1'b1, 1'b0, 3'd0, 64'hE3);
        push_beat(0, 1'b1, 1'b0, 1'b0, 3'd0, 64'hF0);
        push_beat(0, 1'b0, 1'b1, 1'b0, 3'd0, 64'hF1);
        drive_inputs();
        repeat (20) step();
        check_val("nest_beats", 64'(olog.size()), 64'd6);
        if (olog.size() == 6) begin
            check_val("nest_src0", 64'(olog[0].src), 64'd3);
            check_val("nest_src3", 64'(olog[3].src), 64'd3);
            check_val("nest_src4", 64'(olog[4].src), 64'd0);
            check_val("nest_err1", 64'(olog[1].err), 64'd0);
            check_val("nest_err2", 64'(olog[2].err), 64'd1);
            check_val("nest_err3", 64'(olog[3].err), 64'd0);
            check_val("nest_data2", olog[2].data, 64'hE2);
            check_val("nest_eop3", 64'(olog[3].eop), 64'd1);
            check_val("nest_data5", olog[5].data, 64'hF1);
        end
        check_val("nest_drop_cnt", drop_cnt, 64'd2);

        // Single-beat packet from source 1 moves rr_ptr to 2 before the mid-packet reset.
        clear_all();
        push_beat(1, 1'b1, 1'b1, 1'b0, 3'd0, 64'h11);
        drive_inputs();
        repeat (8) step();

        // Reset mid-packet: source 0 granted, two of four beats accepted.
        clear_all();
        for (int j = 0; j < 4; j++) push_beat(0, j == 0, j == 3, 1'b0, 3'd0, 64'h60 + 64'(j));
        drive_inputs();
        repeat (3) step();
        #1;
        check_val("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        check_val("mid_pre_data", bus.out_data, 64'h61);
        system_reset = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid_rst_data", bus.out_data, 64'd0);
        check_val("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        check_val("mid_rst_pkt_cnt", pkt_cnt, 64'd0);
        clear_all();
        @(negedge system_clk);
        hold_reset(2);
        push_beat(1, 1'b1, 1'b1, 1'b0, 3'd0, 64'h71);
        push_beat(3, 1'b1, 1'b1, 1'b0, 3'd0, 64'h73);
        drive_inputs();
        repeat (10) step();
        check_val("post_rst_beats", 64'(olog.size()), 64'd2);
        if (olog.size() == 2) begin
            check_val("post_rst_src0", 64'(olog[0].src), 64'd1);
            check_val("post_rst_src1", 64'(olog[1].src), 64'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
